// File: rtl/bellek_hakemi.sv
// bellek_hakemi: round-robin, burst-capped arbiter sharing the anabellek port between m0 and m1.
// Define HAKEM_ISTATISTIK_EN to add per-master 16-bit saturating wait-cycle counters.
module bellek_hakemi #(
    parameter int                   ADRES_BIT     = 32,
    parameter int                   VERI_BIT      = 32,
    parameter int                   AZAMI_ARDISIK = 4,
    parameter logic [ADRES_BIT-1:0] BELLEK_ADRES  = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m0_istek,
    input  logic [ADRES_BIT-1:0] m0_adres,
    input  logic                 m0_yaz,
    input  logic [VERI_BIT-1:0]  m0_yaz_veri,
    output logic                 m0_hazir,
    output logic [VERI_BIT-1:0]  m0_oku_veri,
    output logic                 m0_oku_gecerli,
    input  logic                 m1_istek,
    input  logic [ADRES_BIT-1:0] m1_adres,
    input  logic                 m1_yaz,
    input  logic [VERI_BIT-1:0]  m1_yaz_veri,
    output logic                 m1_hazir,
    output logic [VERI_BIT-1:0]  m1_oku_veri,
    output logic                 m1_oku_gecerli,
    output logic [ADRES_BIT-1:0] bellek_adres,
    output logic                 bellek_yaz,
    output logic [VERI_BIT-1:0]  bellek_yaz_veri,
`ifdef HAKEM_ISTATISTIK_EN
    output logic [15:0]          m0_bekleme_sayisi,
    output logic [15:0]          m1_bekleme_sayisi,
`endif
    input  logic [VERI_BIT-1:0]  bellek_oku_veri
);
    localparam int AW = $clog2(AZAMI_ARDISIK + 1);
    localparam logic [AW-1:0] AZAMI = AW'(AZAMI_ARDISIK);
    localparam logic [1:0] BOSTA    = 2'd0;
    localparam logic [1:0] M0_SAHIP = 2'd1;
    localparam logic [1:0] M1_SAHIP = 2'd2;

    logic [1:0]    durum;
    logic [1:0]    yeni_sahip;
    logic [AW-1:0] ardisik;
    logic          m0_oncelik;
    logic          g0;
    logic          g1;
    logic          oku_v;
    logic          oku_kim;

    // On contention m0 wins from idle, while it owns an unexhausted burst, or once m1 exhausted its burst
    assign m0_oncelik = (durum == BOSTA) || (durum == M0_SAHIP ? ardisik < AZAMI : ardisik >= AZAMI);
    assign g0         = rst && m0_istek && (!m1_istek || m0_oncelik);
    assign g1         = rst && m1_istek && !g0;
    assign m0_hazir   = g0;
    assign m1_hazir   = g1;
    assign yeni_sahip = g0 ? M0_SAHIP : M1_SAHIP;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum   <= BOSTA;
            ardisik <= '0;
        end else if (g0 || g1) begin
            durum   <= yeni_sahip;
            ardisik <= durum != yeni_sahip ? AW'(1) : ardisik == AZAMI ? AZAMI : ardisik + 1'b1;
        end else begin
            durum   <= BOSTA;
            ardisik <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bellek_adres    <= BELLEK_ADRES;
            bellek_yaz_veri <= '0;
            bellek_yaz      <= 1'b0;
            oku_v           <= 1'b0;
            oku_kim         <= 1'b0;
        end else begin
            bellek_yaz <= (g0 && m0_yaz) || (g1 && m1_yaz);
            oku_v      <= (g0 && !m0_yaz) || (g1 && !m1_yaz);
            oku_kim    <= g1;
            if (g0 || g1) begin
                bellek_adres    <= g0 ? m0_adres : m1_adres;
                bellek_yaz_veri <= g0 ? m0_yaz_veri : m1_yaz_veri;
            end
        end
    end

    // Read data is captured one cycle after the address goes out and steered by the issuing tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_oku_veri    <= '0;
            m1_oku_veri    <= '0;
            m0_oku_gecerli <= 1'b0;
            m1_oku_gecerli <= 1'b0;
        end else begin
            m0_oku_gecerli <= oku_v && !oku_kim;
            m1_oku_gecerli <= oku_v && oku_kim;
            if (oku_v && !oku_kim) m0_oku_veri <= bellek_oku_veri;
            if (oku_v && oku_kim) m1_oku_veri <= bellek_oku_veri;
        end
    end

`ifdef HAKEM_ISTATISTIK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_bekleme_sayisi <= '0;
            m1_bekleme_sayisi <= '0;
        end else begin
            if (m0_istek && !g0 && m0_bekleme_sayisi != 16'hFFFF) m0_bekleme_sayisi <= m0_bekleme_sayisi + 1'b1;
            if (m1_istek && !g1 && m1_bekleme_sayisi != 16'hFFFF) m1_bekleme_sayisi <= m1_bekleme_sayisi + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bellek_hakemi.sv
// tb_bellek_hakemi: directed scenarios plus randomized traffic checked against a behavioural arbiter model.
module tb_bellek_hakemi;
    localparam int AZAMI = 4;

    typedef struct {
        int          due;
        int          m;
        logic [31:0] d;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_istek, m0_yaz, m0_hazir, m0_oku_gecerli;
    logic [31:0] m0_adres, m0_yaz_veri, m0_oku_veri;
    logic        m1_istek, m1_yaz, m1_hazir, m1_oku_gecerli;
    logic [31:0] m1_adres, m1_yaz_veri, m1_oku_veri;
    logic [31:0] bellek_adres, bellek_yaz_veri, bellek_oku_veri;
    logic        bellek_yaz;
`ifdef HAKEM_ISTATISTIK_EN
    logic [15:0] m0_bekleme_sayisi, m1_bekleme_sayisi;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] bellek_icerik(input logic [31:0] a);
        return a == 32'h8000_0010 ? 32'hDEAD_BEEF : {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
    endfunction
    assign bellek_oku_veri = bellek_icerik(bellek_adres);

    bellek_hakemi dut (
        .clk(clk), .rst(rst),
        .m0_istek(m0_istek), .m0_adres(m0_adres), .m0_yaz(m0_yaz), .m0_yaz_veri(m0_yaz_veri),
        .m0_hazir(m0_hazir), .m0_oku_veri(m0_oku_veri), .m0_oku_gecerli(m0_oku_gecerli),
        .m1_istek(m1_istek), .m1_adres(m1_adres), .m1_yaz(m1_yaz), .m1_yaz_veri(m1_yaz_veri),
        .m1_hazir(m1_hazir), .m1_oku_veri(m1_oku_veri), .m1_oku_gecerli(m1_oku_gecerli),
        .bellek_adres(bellek_adres), .bellek_yaz(bellek_yaz), .bellek_yaz_veri(bellek_yaz_veri),
`ifdef HAKEM_ISTATISTIK_EN
        .m0_bekleme_sayisi(m0_bekleme_sayisi), .m1_bekleme_sayisi(m1_bekleme_sayisi),
`endif
        .bellek_oku_veri(bellek_oku_veri)
    );

    task automatic sur(input int m, input logic istek, input logic [31:0] adres, input logic yaz,
                       input logic [31:0] veri);
        if (m == 0) begin
            m0_istek = istek; m0_adres = adres; m0_yaz = yaz; m0_yaz_veri = veri;
        end else begin
            m1_istek = istek; m1_adres = adres; m1_yaz = yaz; m1_yaz_veri = veri;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        sur(0, 1'b1, 32'h8000_0040, 1'b0, 32'h0);
        sur(1, 1'b1, 32'h8000_0080, 1'b1, 32'h1);
        #12;
        n_chk++;
        if ({m0_hazir, m1_hazir, bellek_yaz, m0_oku_gecerli, m1_oku_gecerli} !== 5'b0 ||
            bellek_adres !== 32'h8000_0000 || bellek_yaz_veri !== 32'h0 ||
            m0_oku_veri !== 32'h0 || m1_oku_veri !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold: hazir=%b%b yaz=%b adres=%h wd=%h rd=%h/%h, required 00 0 80000000 0 0/0",
                     m0_hazir, m1_hazir, bellek_yaz, bellek_adres, bellek_yaz_veri, m0_oku_veri, m1_oku_veri);
        end
        sur(0, 1'b0, 32'h0, 1'b0, 32'h0);
        sur(1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bellek_adres, bellek_yaz, m0_hazir, m1_hazir, m0_oku_gecerli, m1_oku_gecerli} !==
                {32'h8000_0000, 5'b0}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: adres=%h yaz=%b hazir=%b%b gecerli=%b%b, required 80000000 0 00 00",
                         i, bellek_adres, bellek_yaz, m0_hazir, m1_hazir, m0_oku_gecerli, m1_oku_gecerli);
            end
        end
    endtask

    task automatic test_single_read;
        @(posedge clk); #1 sur(0, 1'b1, 32'h8000_0010, 1'b0, 32'h0);
        @(negedge clk);
        n_chk++;
        if ({m0_hazir, m1_hazir} !== 2'b10) begin
            n_fail++; $display("FAIL read_accept: hazir=%b%b, required 10", m0_hazir, m1_hazir);
        end
        @(posedge clk); #1 sur(0, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bellek_adres !== 32'h8000_0010 || bellek_yaz !== 1'b0 || m0_oku_gecerli !== 1'b0) begin
            n_fail++;
            $display("FAIL read_addr: adres=%h yaz=%b gecerli=%b, required 80000010 0 0",
                     bellek_adres, bellek_yaz, m0_oku_gecerli);
        end
        @(negedge clk);
        n_chk++;
        if (m0_oku_gecerli !== 1'b1 || m0_oku_veri !== 32'hDEAD_BEEF || m1_oku_gecerli !== 1'b0) begin
            n_fail++;
            $display("FAIL read_return: gecerli=%b%b veri=%h, required 10 deadbeef",
                     m0_oku_gecerli, m1_oku_gecerli, m0_oku_veri);
        end
        @(negedge clk);
        n_chk++;
        if (m0_oku_gecerli !== 1'b0 || m0_oku_veri !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_pulse_end: gecerli=%b veri=%h, required 0 deadbeef", m0_oku_gecerli, m0_oku_veri);
        end
    endtask

    task automatic test_single_write;
        @(posedge clk); #1 sur(1, 1'b1, 32'h8000_0100, 1'b1, 32'h1234_5678);
        @(negedge clk);
        n_chk++;
        if ({m0_hazir, m1_hazir} !== 2'b01) begin
            n_fail++; $display("FAIL write_accept: hazir=%b%b, required 01", m0_hazir, m1_hazir);
        end
        @(posedge clk); #1 sur(1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        n_chk++;
        if (bellek_yaz !== 1'b1 || bellek_adres !== 32'h8000_0100 || bellek_yaz_veri !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL write_port: yaz=%b adres=%h wd=%h, required 1 80000100 12345678",
                     bellek_yaz, bellek_adres, bellek_yaz_veri);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_chk++;
            if ({bellek_yaz, m0_oku_gecerli, m1_oku_gecerli} !== 3'b000) begin
                n_fail++;
                $display("FAIL write_after[%0d]: yaz=%b gecerli=%b%b, required 0 00",
                         i, bellek_yaz, m0_oku_gecerli, m1_oku_gecerli);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [1:0] exp;
        @(posedge clk); #1;
        sur(0, 1'b1, 32'h8000_0200, 1'b0, 32'h0);
        sur(1, 1'b1, 32'h8000_0300, 1'b0, 32'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            exp = (i / AZAMI) % 2 == 0 ? 2'b10 : 2'b01;
            n_chk++;
            if ({m0_hazir, m1_hazir} !== exp) begin
                n_fail++; $display("FAIL rr_grant[%0d]: hazir=%b%b, required %b", i, m0_hazir, m1_hazir, exp);
            end
`ifdef HAKEM_ISTATISTIK_EN
            if (i == 4) begin
                n_chk++;
                if (m1_bekleme_sayisi !== 16'd4) begin
                    n_fail++; $display("FAIL rr_m1_wait: got %0d, required 4", m1_bekleme_sayisi);
                end
            end
            if (i == 11) begin
                n_chk++;
                if (m0_bekleme_sayisi !== 16'd4 || m1_bekleme_sayisi !== 16'd7) begin
                    n_fail++;
                    $display("FAIL rr_wait_end: got %0d/%0d, required 4/7", m0_bekleme_sayisi, m1_bekleme_sayisi);
                end
            end
`endif
            @(posedge clk); #1;
        end
        sur(0, 1'b0, 32'h0, 1'b0, 32'h0);
        sur(1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_owner_drop;
        logic [1:0] exp_seq [7] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            sur(0, i != 2, 32'h8000_0400, 1'b1, 32'hAAAA_0000);
            sur(1, 1'b1, 32'h8000_0500, 1'b1, 32'hBBBB_0000);
            @(negedge clk);
            n_chk++;
            if ({m0_hazir, m1_hazir} !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL drop_grant[%0d]: hazir=%b%b, required %b", i, m0_hazir, m1_hazir, exp_seq[i]);
            end
        end
        @(posedge clk); #1;
        sur(0, 1'b0, 32'h0, 1'b0, 32'h0);
        sur(1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_read;
        @(posedge clk); #1 sur(0, 1'b1, 32'h8000_0010, 1'b0, 32'hCAFE_F00D);
        @(negedge clk);
        n_chk++;
        if (m0_hazir !== 1'b1) begin
            n_fail++; $display("FAIL mid_accept: m0_hazir=%b, required 1", m0_hazir);
        end
        @(posedge clk); #1;
        sur(0, 1'b0, 32'h0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        n_chk++;
        if (bellek_adres !== 32'h8000_0000 || bellek_yaz_veri !== 32'h0 || bellek_yaz !== 1'b0 ||
            m0_oku_veri !== 32'h0 || m1_oku_veri !== 32'h0 || {m0_oku_gecerli, m1_oku_gecerli} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_reset: adres=%h wd=%h yaz=%b rd=%h/%h gecerli=%b%b, required 80000000 0 0 0/0 00",
                     bellek_adres, bellek_yaz_veri, bellek_yaz, m0_oku_veri, m1_oku_veri,
                     m0_oku_gecerli, m1_oku_gecerli);
        end
`ifdef HAKEM_ISTATISTIK_EN
        n_chk++;
        if (m0_bekleme_sayisi !== 16'd0 || m1_bekleme_sayisi !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_stats: got %0d/%0d, required 0/0", m0_bekleme_sayisi, m1_bekleme_sayisi);
        end
`endif
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if ({m0_oku_gecerli, m1_oku_gecerli} !== 2'b00 || m0_oku_veri !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_no_pulse[%0d]: gecerli=%b%b veri=%h, required 00 0",
                         i, m0_oku_gecerli, m1_oku_gecerli, m0_oku_veri);
            end
        end
    endtask

    task automatic test_back_to_back_random;
        int          sahip = -1;
        int          ard = 0;
        int          g;
        logic        act [2] = '{1'b0, 1'b0};
        logic [31:0] t_adres [2];
        logic        t_yaz [2];
        logic [31:0] t_wd [2];
        logic [31:0] e_rd [2] = '{32'h0, 32'h0};
        logic        e_g [2];
        int          bekle [2] = '{0, 0};
        logic [31:0] e_adres = 32'h8000_0000;
        logic [31:0] e_wd = 32'h0;
        logic        e_yaz = 1'b0;
        ret_t        rq [$];
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (!act[m] && $urandom_range(0, 99) < 65) begin
                    act[m]     = 1'b1;
                    t_adres[m] = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
                    t_yaz[m]   = 1'($urandom_range(0, 1));
                    t_wd[m]    = $urandom;
                end
                sur(m, act[m], t_adres[m], t_yaz[m], t_wd[m]);
            end
            @(negedge clk);
            if (!act[0] && !act[1]) g = -1;
            else if (act[0] != act[1]) g = act[0] ? 0 : 1;
            else if (sahip < 0) g = 0;
            else g = ard < AZAMI ? sahip : 1 - sahip;
            n_chk++;
            if ({m0_hazir, m1_hazir} !== {g == 0, g == 1}) begin
                n_fail++;
                $display("FAIL rnd_grant[%0d]: hazir=%b%b, required %b%b", c, m0_hazir, m1_hazir, g == 0, g == 1);
            end
            n_chk++;
            if ({bellek_adres, bellek_yaz, bellek_yaz_veri} !== {e_adres, e_yaz, e_wd}) begin
                n_fail++;
                $display("FAIL rnd_port[%0d]: adres=%h yaz=%b wd=%h, required %h %b %h",
                         c, bellek_adres, bellek_yaz, bellek_yaz_veri, e_adres, e_yaz, e_wd);
            end
            e_g[0] = 1'b0;
            e_g[1] = 1'b0;
            if (rq.size() > 0 && rq[0].due == c) begin
                e_g[rq[0].m]  = 1'b1;
                e_rd[rq[0].m] = rq[0].d;
                void'(rq.pop_front());
            end
            n_chk++;
            if ({m0_oku_gecerli, m1_oku_gecerli, m0_oku_veri, m1_oku_veri} !== {e_g[0], e_g[1], e_rd[0], e_rd[1]}) begin
                n_fail++;
                $display("FAIL rnd_return[%0d]: gecerli=%b%b veri=%h/%h, required %b%b %h/%h",
                         c, m0_oku_gecerli, m1_oku_gecerli, m0_oku_veri, m1_oku_veri,
                         e_g[0], e_g[1], e_rd[0], e_rd[1]);
            end
`ifdef HAKEM_ISTATISTIK_EN
            n_chk++;
            if (m0_bekleme_sayisi !== 16'(bekle[0]) || m1_bekleme_sayisi !== 16'(bekle[1])) begin
                n_fail++;
                $display("FAIL rnd_wait[%0d]: got %0d/%0d, required %0d/%0d",
                         c, m0_bekleme_sayisi, m1_bekleme_sayisi, bekle[0], bekle[1]);
            end
`endif
            for (int m = 0; m < 2; m++) if (act[m] && g != m && bekle[m] < 65535) bekle[m]++;
            if (g >= 0) begin
                e_adres = t_adres[g];
                e_wd    = t_wd[g];
                e_yaz   = t_yaz[g];
                if (!t_yaz[g]) rq.push_back('{due: c + 2, m: g, d: bellek_icerik(t_adres[g])});
                ard     = g == sahip ? (ard < AZAMI ? ard + 1 : AZAMI) : 1;
                sahip   = g;
                act[g]  = 1'b0;
            end else begin
                e_yaz = 1'b0;
                sahip = -1;
                ard   = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_owner_drop();
        test_reset_mid_read();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bellek_hakemi.md
Name: bellek_hakemi

Overview:
Two-master arbiter that shares the single `anabellek` port (address, write data, write strobe, read data) between the `islemci` core (m0) and a second bus master such as a program loader or DMA (m1).
- Each master uses a request/ready handshake.
- The arbiter registers the winning transaction onto the memory port and returns read data to the issuing master two cycles after acceptance.
- Round-robin arbitration with a burst cap prevents either master from starving the other.

Parameters:
ADRES_BIT, 32, address width.
VERI_BIT, 32, data width.
AZAMI_ARDISIK, 4, maximum consecutive grants to one master while the other is requesting (>=1).
BELLEK_ADRES, 32'h8000_0000, bellek_adres value after reset.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-low reset.
m0_istek  input  1  m0 transaction request.
m0_adres  input  ADRES_BIT  m0 address.
m0_yaz  input  1  1 = write, 0 = read.
m0_yaz_veri  input  VERI_BIT  m0 write data.
m0_hazir  output  1  m0 transaction accepted this cycle (combinational).
m0_oku_veri  output  VERI_BIT  m0 read data.
m0_oku_gecerli  output  1  m0_oku_veri valid, one-cycle pulse.
m1_istek, m1_adres, m1_yaz, m1_yaz_veri, m1_hazir, m1_oku_veri, m1_oku_gecerli  same as m0.
bellek_adres  output  ADRES_BIT  registered memory address.
bellek_yaz  output  1  registered write strobe.
bellek_yaz_veri  output  VERI_BIT  registered write data.
bellek_oku_veri  input  VERI_BIT  memory read data for the current bellek_adres.

Behaviour:
- Reset (rst=0, asynchronous) sets all of the following immediately:
  - bellek_adres=BELLEK_ADRES, bellek_yaz=0, bellek_yaz_veri=0.
  - mX_oku_veri=0, mX_oku_gecerli=0.
  - State BOSTA, ardisik counter 0, pending-read tag cleared.
  - mX_hazir=0 while reset is asserted.
- Handshake:
  - A transaction is accepted in cycle N when mX_istek && mX_hazir.
  - At most one master is accepted per cycle.
  - A master holds its request and operands stable until it sees hazir.
- States: BOSTA (no owner), M0_SAHIP, M1_SAHIP (owner = last granted master).
- Grant rules (evaluated each cycle):
  - Only one master requesting: it wins.
  - Both requesting in BOSTA: m0 wins.
  - Both requesting with an owner: the owner wins if ardisik < AZAMI_ARDISIK; otherwise the other master wins.
  - Neither requesting: no grant; next state BOSTA, ardisik <= 0.
- Counter and state update on a grant:
  - Grant to the current owner: ardisik <= ardisik+1, saturating at AZAMI_ARDISIK.
  - Grant to the other master (or from BOSTA): ardisik <= 1, state <= that master's SAHIP.
- Memory port:
  - Cycle N+1: bellek_adres, bellek_yaz_veri and bellek_yaz (= mX_yaz) reflect the accepted transaction.
  - bellek_yaz is a one-cycle pulse.
  - On idle cycles bellek_adres and bellek_yaz_veri hold their values and bellek_yaz=0.
- Read return:
  - For an accepted read, bellek_oku_veri is sampled at the end of cycle N+1.
  - In cycle N+2, the issuing master gets mX_oku_veri = that value with mX_oku_gecerli=1 for exactly one cycle.
  - The other master's gecerli stays 0; mX_oku_veri holds its value otherwise.
  - Writes produce no gecerli pulse.
- Back-to-back: reads from both masters in consecutive cycles are fully pipelined; each return is tagged to its own master.
- Reset mid-operation: any in-flight read is dropped and no gecerli pulse appears after reset release.

Optional Feature:
HAKEM_ISTATISTIK_EN
- Defined: adds outputs m0_bekleme_sayisi and m1_bekleme_sayisi (16-bit each, reset 0).
  - Each increments once per cycle in which mX_istek=1 and mX_hazir=0.
  - Saturates at 16'hFFFF.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset released, no requests -> bellek_adres=0x8000_0000, bellek_yaz=0, all hazir/gecerli 0 for 10 cycles.
2. m0 read 0x8000_0010 alone, memory word 0xDEADBEEF -> m0_hazir=1 in cycle N; bellek_adres=0x8000_0010 in N+1; m0_oku_gecerli=1, m0_oku_veri=0xDEADBEEF in N+2 only.
3. m1 write 0x8000_0100 / 0x1234_5678 -> bellek_yaz=1 for exactly one cycle with that address/data; no m1_oku_gecerli.
4. Both request continuously from BOSTA, AZAMI_ARDISIK=4 -> grant sequence m0×4, m1×4, m0×4; no cycle without a grant.
5. Owner m0 drops its request after 2 grants while m1 requests -> m1 granted the next cycle, ardisik=1.
6. rst=0 in cycle N+1 of an m0 read -> outputs at reset values immediately, no m0_oku_gecerli pulse after release. With HAKEM_ISTATISTIK_EN, in the scenario 4 sequence, m1_bekleme_sayisi=4 once m1's first grant is issued.
